// File: rtl/mem_wb_stage.sv
// Memory-access stage with a multi-cycle word RAM feeding the MEM/WB register.
// Stalls upstream for MEM_LATENCY-1 cycles per access; branch decision is combinational.
module mem_wb_stage #(
    parameter int ADDR_BITS   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Sig_MemRead,
    input  logic        i_Sig_MemWrite,
    input  logic        i_Sig_MemtoReg,
    input  logic        i_Sig_RegWrite,
    input  logic        i_Sig_Branch,
    input  logic [15:0] i_Branch_Target,
    input  logic [15:0] i_ALU_Result,
    input  logic        i_ALU_Zero,
    input  logic [15:0] i_Write_Data,
    input  logic [2:0]  i_Write_Register,
    output logic        o_PCSrc,
    output logic [15:0] o_Branch_Target,
    output logic        o_Stall,
    output logic        o_Sig_RegWrite,
    output logic        o_Sig_MemtoReg,
    output logic [15:0] o_Read_Data,
    output logic [15:0] o_ALU_Result,
    output logic [2:0]  o_Write_Register
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] BUSY     = 1'b1;
    localparam logic       MULTI    = (MEM_LATENCY > 1);
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(MEM_LATENCY - 2) : 4'd0;

    logic [0:0]           state;
    logic [3:0]           cnt;
    logic [15:0]          mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] addr;
    logic                 req;
    logic                 is_load;
    logic                 stall;
    logic                 done;

    assign addr    = i_ALU_Result[ADDR_BITS-1:0];
    assign req     = i_Sig_MemRead | i_Sig_MemWrite;
    // A simultaneous read+write is a store; only a pure read returns data.
    assign is_load = i_Sig_MemRead & ~i_Sig_MemWrite;

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        if (state == BUSY) begin
            stall = (cnt != 4'd0);
            done  = (cnt == 4'd0);
        end else if (req) begin
            stall = MULTI;
            done  = ~MULTI;
        end
    end

    // Gating with reset drops the stall the instant reset asserts, even with a request still presented.
    assign o_Stall         = stall & reset;
    assign o_PCSrc         = i_Sig_Branch & i_ALU_Zero & ~o_Stall;
    assign o_Branch_Target = i_Branch_Target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (state == IDLE) begin
            if (req && MULTI) begin
                state <= BUSY;
                cnt   <= CNT_INIT;
            end
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && done && i_Sig_MemWrite) begin
            mem[addr] <= i_Write_Data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_Sig_RegWrite   <= 1'b0;
            o_Sig_MemtoReg   <= 1'b0;
            o_Read_Data      <= 16'd0;
            o_ALU_Result     <= 16'd0;
            o_Write_Register <= 3'd0;
        end else if (stall) begin
            o_Sig_RegWrite   <= 1'b0;
            o_Sig_MemtoReg   <= 1'b0;
            o_Read_Data      <= 16'd0;
            o_ALU_Result     <= 16'd0;
            o_Write_Register <= 3'd0;
        end else begin
            o_Sig_RegWrite   <= i_Sig_RegWrite;
            o_Sig_MemtoReg   <= i_Sig_MemtoReg;
            o_Read_Data      <= (done && is_load) ? mem[addr] : 16'd0;
            o_ALU_Result     <= i_ALU_Result;
            o_Write_Register <= i_Write_Register;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances (latency 2, 1, 4) with a queue of expected MEM/WB captures.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [15:0] rdata;
        logic [15:0] alu;
        logic [2:0]  wreg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [3];
    logic        rd     [3];
    logic        wr     [3];
    logic        m2r_i  [3];
    logic        rw_i   [3];
    logic        br     [3];
    logic        z      [3];
    logic [15:0] tgt    [3];
    logic [15:0] alu_i  [3];
    logic [15:0] wd_i   [3];
    logic [2:0]  wreg_i [3];
    logic        pcsrc  [3];
    logic [15:0] tgt_o  [3];
    logic        st     [3];
    logic        rw_o   [3];
    logic        m2r_o  [3];
    logic [15:0] rdat   [3];
    logic [15:0] alu_o  [3];
    logic [2:0]  wreg_o [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_wb_stage #(
            .ADDR_BITS  (8),
            .MEM_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) dut (
            .clk             (clk),
            .reset           (rst[g]),
            .i_Sig_MemRead   (rd[g]),
            .i_Sig_MemWrite  (wr[g]),
            .i_Sig_MemtoReg  (m2r_i[g]),
            .i_Sig_RegWrite  (rw_i[g]),
            .i_Sig_Branch    (br[g]),
            .i_Branch_Target (tgt[g]),
            .i_ALU_Result    (alu_i[g]),
            .i_ALU_Zero      (z[g]),
            .i_Write_Data    (wd_i[g]),
            .i_Write_Register(wreg_i[g]),
            .o_PCSrc         (pcsrc[g]),
            .o_Branch_Target (tgt_o[g]),
            .o_Stall         (st[g]),
            .o_Sig_RegWrite  (rw_o[g]),
            .o_Sig_MemtoReg  (m2r_o[g]),
            .o_Read_Data     (rdat[g]),
            .o_ALU_Result    (alu_o[g]),
            .o_Write_Register(wreg_o[g])
        );
    end

    task automatic drive(input int s, input logic r, input logic w, input logic m2r,
                         input logic rw, input logic [15:0] alu, input logic [15:0] wd,
                         input logic [2:0] wreg);
        rd[s]     = r;
        wr[s]     = w;
        m2r_i[s]  = m2r;
        rw_i[s]   = rw;
        alu_i[s]  = alu;
        wd_i[s]   = wd;
        wreg_i[s] = wreg;
        br[s]     = 1'b0;
        z[s]      = 1'b0;
        tgt[s]    = 16'd0;
    endtask

    // Called just after a rising edge; returns just after the completion edge.
    task automatic access(input int s, input logic r, input logic w, input logic m2r,
                          input logic rw, input logic [15:0] alu, input logic [15:0] wd,
                          input logic [2:0] wreg, input int exp_stall,
                          input logic [15:0] exp_rd, input string nm);
        exp_t e;
        exp_t got;
        int   n;
        drive(s, r, w, m2r, rw, alu, wd, wreg);
        e.rw    = rw;
        e.m2r   = m2r;
        e.rdata = exp_rd;
        e.alu   = alu;
        e.wreg  = wreg;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (st[s] === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            checks++;
            if ({rw_o[s], m2r_o[s], rdat[s], alu_o[s], wreg_o[s]} !== 37'd0) begin
                errors++;
                $display("FAIL %s bubble got rw=%b m2r=%b rd=%h alu=%h wreg=%0d want all 0",
                         nm, rw_o[s], m2r_o[s], rdat[s], alu_o[s], wreg_o[s]);
            end
            @(negedge clk);
        end
        checks++;
        if (n != exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d want %0d", nm, n, exp_stall);
        end
        @(posedge clk);
        #1;
        got = {rw_o[s], m2r_o[s], rdat[s], alu_o[s], wreg_o[s]};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty got %h", nm, got);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s capture got rw=%b m2r=%b rd=%h alu=%h wreg=%0d want rw=%b m2r=%b rd=%h alu=%h wreg=%0d",
                         nm, got.rw, got.m2r, got.rdata, got.alu, got.wreg,
                         e.rw, e.m2r, e.rdata, e.alu, e.wreg);
            end
        end
        drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rst[s] = 1'b0;
            drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({st[s], pcsrc[s], rw_o[s], m2r_o[s], rdat[s], alu_o[s], wreg_o[s]} !== 39'd0) begin
                errors++;
                $display("FAIL reset dut%0d got st=%b pc=%b rw=%b m2r=%b rd=%h alu=%h wreg=%0d want all 0",
                         s, st[s], pcsrc[s], rw_o[s], m2r_o[s], rdat[s], alu_o[s], wreg_o[s]);
            end
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) rst[s] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 16'hBEEF, 3'd0, 1, 16'h0000, "store_12");
        access(0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0000, 3'd5, 1, 16'hBEEF, "load_12");
    endtask

    task automatic test_passthrough();
        access(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 3'd3, 0, 16'h0000, "alu_op");
    endtask

    task automatic test_latency();
        access(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h4242, 3'd0, 0, 16'h0000, "lat1_store");
        access(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0007, 16'h0000, 3'd2, 0, 16'h4242, "lat1_load");
        access(2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h9999, 3'd0, 3, 16'h0000, "lat4_store");
        access(2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd6, 3, 16'h9999, "lat4_load");
    endtask

    task automatic test_wrap();
        access(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0105, 16'h1234, 3'd0, 1, 16'h0000, "wrap_store");
        access(0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, 3'd4, 1, 16'h1234, "wrap_load");
    endtask

    task automatic test_branch();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        br[0] = 1'b1; z[0] = 1'b1; tgt[0] = 16'h0040;
        @(negedge clk);
        checks++;
        if (pcsrc[0] !== 1'b1 || tgt_o[0] !== 16'h0040) begin
            errors++;
            $display("FAIL branch_taken got pc=%b tgt=%h want pc=1 tgt=0040", pcsrc[0], tgt_o[0]);
        end
        @(posedge clk);
        #1;
        z[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (pcsrc[0] !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken got pc=%b want 0", pcsrc[0]);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 16'd0, 3'd0);
        br[0] = 1'b1; z[0] = 1'b1; tgt[0] = 16'h0080;
        @(negedge clk);
        checks++;
        if (st[0] !== 1'b1 || pcsrc[0] !== 1'b0) begin
            errors++;
            $display("FAIL branch_in_stall got st=%b pc=%b want st=1 pc=0", st[0], pcsrc[0]);
        end
        @(negedge clk);
        checks++;
        if (st[0] !== 1'b0 || pcsrc[0] !== 1'b1) begin
            errors++;
            $display("FAIL branch_after_stall got st=%b pc=%b want st=0 pc=1", st[0], pcsrc[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rdat[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL branch_load got rd=%h want beef", rdat[0]);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    endtask

    task automatic test_both_flags();
        access(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h00AA, 3'd0, 1, 16'h0000, "both_flags");
        access(0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd7, 1, 16'h00AA, "both_reload");
    endtask

    task automatic test_reset_mid();
        access(2, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h1111, 3'd0, 3, 16'h0000, "preload_30");
        drive(2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h5555, 3'd2);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        checks++;
        if ({st[2], pcsrc[2], rw_o[2], m2r_o[2], rdat[2], alu_o[2], wreg_o[2]} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid got st=%b pc=%b rw=%b m2r=%b rd=%h alu=%h wreg=%0d want all 0",
                     st[2], pcsrc[2], rw_o[2], m2r_o[2], rdat[2], alu_o[2], wreg_o[2]);
        end
        drive(2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        access(2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 3'd1, 3, 16'h1111, "reload_30");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_passthrough();
        test_latency();
        test_wrap();
        test_branch();
        test_both_flags();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage sitting directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM control and data signals and performs data-memory reads and writes against an internal word-addressed RAM with a configurable multi-cycle latency.
- Resolves the branch decision and registers the results into the MEM/WB pipeline register that feeds write-back.
- While an access is in progress it asserts a stall to hold the upstream pipeline.

Parameters:
- ADDR_BITS, 8, data-memory address width in words; depth = 2**ADDR_BITS words of 16 bits.
- MEM_LATENCY, 2, cycles per memory access, legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_Sig_MemRead  input  1  load request.
- i_Sig_MemWrite  input  1  store request.
- i_Sig_MemtoReg  input  1  write-back selects memory data.
- i_Sig_RegWrite  input  1  instruction writes the register file.
- i_Sig_Branch  input  1  instruction is a branch.
- i_Branch_Target  input  16  branch destination PC.
- i_ALU_Result  input  16  memory address (word) or ALU value for write-back.
- i_ALU_Zero  input  1  ALU zero flag.
- i_Write_Data  input  16  store data.
- i_Write_Register  input  3  destination register.
- o_PCSrc  output  1  branch taken.
- o_Branch_Target  output  16  branch destination passthrough.
- o_Stall  output  1  hold upstream stages; inputs must stay stable while high.
- o_Sig_RegWrite  output  1  MEM/WB register-write enable.
- o_Sig_MemtoReg  output  1  MEM/WB write-back select.
- o_Read_Data  output  16  MEM/WB loaded data.
- o_ALU_Result  output  16  MEM/WB ALU value.
- o_Write_Register  output  3  MEM/WB destination register.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE and the latency counter clears.
  - All MEM/WB outputs clear to 0.
  - RAM contents are not reset.
  - Reset asserted mid-access aborts the access with no write performed.
- Address: word index = i_ALU_Result[ADDR_BITS-1:0]; upper bits are ignored, so addresses alias and wrap.
- Access type: request = i_Sig_MemRead | i_Sig_MemWrite. When both are set the access is treated as a store and o_Read_Data = 0.
- FSM states IDLE and BUSY, with counter cnt.
  - IDLE, no request: MEM/WB register captures the inputs every edge. o_Read_Data = 0.
  - IDLE, request, MEM_LATENCY=1: the access completes at this edge (store writes the RAM; load captures RAM[addr]). Stay in IDLE.
  - IDLE, request, MEM_LATENCY>1: o_Stall = 1 combinationally. At the edge, go to BUSY with cnt = MEM_LATENCY-2. The MEM/WB register captures a bubble (o_Sig_RegWrite = 0, o_Sig_MemtoReg = 0, other fields 0).
  - BUSY, cnt>0: o_Stall = 1. Decrement cnt, capture a bubble.
  - BUSY, cnt=0: o_Stall = 0. At the edge, complete the access and capture the full instruction into MEM/WB, then return to IDLE.
  - A new request presented in the cycle after completion starts a new access; there is no idle gap.
- Stall length: o_Stall is high for exactly MEM_LATENCY-1 cycles per access.
- Write timing: a store writes the RAM only at the completion edge.
- Load timing: a load returns RAM contents as of the completion edge, which includes any store completed earlier.
- Branch outputs:
  - o_PCSrc = i_Sig_Branch & i_ALU_Zero & ~o_Stall, combinational.
  - o_Branch_Target = i_Branch_Target, combinational.
- Input stability: inputs are required stable while o_Stall = 1. Changes during BUSY are undefined; the bench must not generate them.

Test Plan:
1. Store then load (default parameters): store 0xBEEF to address 0x12, then load 0x12 with RegWrite=1, MemtoReg=1, Write_Register=5. Required: each access raises o_Stall for 1 cycle; after the load completes, o_Read_Data = 0xBEEF, o_Write_Register = 5, o_Sig_RegWrite = 1.
2. Latency sweep: MEM_LATENCY = 1, then 4, with a single load. Required: o_Stall high for 0 cycles and 3 cycles respectively; exactly one MEM/WB capture with RegWrite=1, and bubbles (RegWrite=0) before it.
3. Address wrap: store 0x1234 with i_ALU_Result = 0x0105, then load with i_ALU_Result = 0x0005. Required: o_Read_Data = 0x1234.
4. Branch:
   - Branch=1, Zero=1, target 0x0040, no memory access. Required: o_PCSrc = 1 and o_Branch_Target = 0x0040 in the same cycle.
   - Branch=1, Zero=0. Required: o_PCSrc = 0.
5. Both flags set: MemRead = MemWrite = 1, data 0x00AA, address 0x20. Required: o_Read_Data = 0; a later load of address 0x20 returns 0x00AA.
6. Reset mid-access: address 0x30 preloaded with 0x1111; start a store of 0x5555 to 0x30 with MEM_LATENCY=4 and drop reset during BUSY. Required: o_Stall and all outputs go to 0 immediately; a later load of 0x30 returns 0x1111.
